// File: rtl/arch_map_table.sv
// Architectural (committed) map table for the retirement side of rename.
// Holds the committed logical-to-physical mapping and updates it for up to
// four retiring instructions per cycle. Each displaced physical tag is sent
// back to the speculative free list. On a recovery flush the whole committed
// mapping is streamed out, four entries per cycle, to the speculative map table.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   commit{Valid,HasDest,LogDest,PhyDest}N_i  retiring slot N (0 = oldest)
//   recoverFlag_i               flush pulse; starts or restarts the walk
//   freedValidN_o / freedRegN_o registered release of displaced tags
//   recoverBusy_o               walk in progress
//   recoverWrValid_o / recoverWrIdx_o / recoverWrPhyK_o  walk group output
module arch_map_table #(
  parameter int unsigned SIZE_RMT          = 32,
  parameter int unsigned SIZE_RMT_LOG      = 5,
  parameter int unsigned SIZE_PHYSICAL_LOG = 7
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic                         commitValid0_i,
  input  logic                         commitValid1_i,
  input  logic                         commitValid2_i,
  input  logic                         commitValid3_i,
  input  logic                         commitHasDest0_i,
  input  logic                         commitHasDest1_i,
  input  logic                         commitHasDest2_i,
  input  logic                         commitHasDest3_i,
  input  logic [SIZE_RMT_LOG-1:0]      commitLogDest0_i,
  input  logic [SIZE_RMT_LOG-1:0]      commitLogDest1_i,
  input  logic [SIZE_RMT_LOG-1:0]      commitLogDest2_i,
  input  logic [SIZE_RMT_LOG-1:0]      commitLogDest3_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest0_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest1_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest2_i,
  input  logic [SIZE_PHYSICAL_LOG-1:0] commitPhyDest3_i,

  input  logic                         recoverFlag_i,

  output logic                         freedValid0_o,
  output logic                         freedValid1_o,
  output logic                         freedValid2_o,
  output logic                         freedValid3_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freedReg0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freedReg1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freedReg2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] freedReg3_o,

  output logic                         recoverBusy_o,
  output logic                         recoverWrValid_o,
  output logic [SIZE_RMT_LOG-3:0]      recoverWrIdx_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverWrPhy0_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverWrPhy1_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverWrPhy2_o,
  output logic [SIZE_PHYSICAL_LOG-1:0] recoverWrPhy3_o
);

  localparam int unsigned NumGroups = SIZE_RMT / 4;
  localparam int unsigned GrpW      = SIZE_RMT_LOG - 2;

  typedef logic [SIZE_PHYSICAL_LOG-1:0] phy_t;
  typedef logic [SIZE_RMT_LOG-1:0]      log_t;
  typedef enum logic [0:0] {StIdle, StWalk} state_e;

  // Slot-indexed views of the commit ports
  logic [3:0] commit_valid;
  logic [3:0] eff;
  log_t       log_dest [4];
  phy_t       phy_dest [4];

  assign commit_valid = {commitValid3_i, commitValid2_i, commitValid1_i, commitValid0_i};
  assign eff = commit_valid &
               {commitHasDest3_i, commitHasDest2_i, commitHasDest1_i, commitHasDest0_i};
  assign log_dest[0] = commitLogDest0_i;
  assign log_dest[1] = commitLogDest1_i;
  assign log_dest[2] = commitLogDest2_i;
  assign log_dest[3] = commitLogDest3_i;
  assign phy_dest[0] = commitPhyDest0_i;
  assign phy_dest[1] = commitPhyDest1_i;
  assign phy_dest[2] = commitPhyDest2_i;
  assign phy_dest[3] = commitPhyDest3_i;

  phy_t       table_q [SIZE_RMT];
  phy_t       table_d [SIZE_RMT];
  logic [3:0] freed_valid_q, freed_valid_d;
  phy_t       freed_reg_q [4];
  phy_t       freed_reg_d [4];

  // Slots are processed oldest to youngest: a younger slot displaces the tag
  // written by the youngest older slot with the same destination, and the
  // youngest writer wins the table entry.
  always_comb begin
    table_d       = table_q;
    freed_valid_d = '0;
    for (int n = 0; n < 4; n++) begin
      freed_reg_d[n] = '0;
    end
    for (int n = 0; n < 4; n++) begin
      if (eff[n]) begin
        freed_valid_d[n] = 1'b1;
        freed_reg_d[n]   = table_q[log_dest[n]];
        for (int m = 0; m < n; m++) begin
          if (eff[m] && (log_dest[m] == log_dest[n])) begin
            freed_reg_d[n] = phy_dest[m];
          end
        end
        table_d[log_dest[n]] = phy_dest[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SIZE_RMT; k++) begin
        table_q[k] <= phy_t'(k);
      end
      freed_valid_q <= '0;
      for (int n = 0; n < 4; n++) begin
        freed_reg_q[n] <= '0;
      end
    end else begin
      table_q       <= table_d;
      freed_valid_q <= freed_valid_d;
      freed_reg_q   <= freed_reg_d;
    end
  end

  assign freedValid0_o = freed_valid_q[0];
  assign freedValid1_o = freed_valid_q[1];
  assign freedValid2_o = freed_valid_q[2];
  assign freedValid3_o = freed_valid_q[3];
  assign freedReg0_o   = freed_reg_q[0];
  assign freedReg1_o   = freed_reg_q[1];
  assign freedReg2_o   = freed_reg_q[2];
  assign freedReg3_o   = freed_reg_q[3];

  // Recovery walk
  state_e          state_q, state_d;
  logic [GrpW-1:0] ptr_q, ptr_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        ptr_d = '0;
        if (recoverFlag_i) begin
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (recoverFlag_i) begin
          ptr_d = '0;
        end else if (ptr_q == GrpW'(NumGroups - 1)) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + GrpW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Group contents come straight from the registered table, so a commit in
  // the flag cycle is already visible in group 0.
  phy_t wr_phy [4];
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      wr_phy[k] = '0;
      if (state_q == StWalk) begin
        wr_phy[k] = table_q[{ptr_q, 2'(k)}];
      end
    end
  end

  assign recoverBusy_o    = (state_q == StWalk);
  assign recoverWrValid_o = (state_q == StWalk);
  assign recoverWrIdx_o   = ptr_q;
  assign recoverWrPhy0_o  = wr_phy[0];
  assign recoverWrPhy1_o  = wr_phy[1];
  assign recoverWrPhy2_o  = wr_phy[2];
  assign recoverWrPhy3_o  = wr_phy[3];

  // Retire must hold commits while the walk runs; they are still applied so
  // no tag leaks, but already-emitted groups are stale.
  a_no_commit_in_walk : assert property (
    @(posedge clk) disable iff (reset) (state_q == StWalk) |-> (commit_valid == 4'b0000));

endmodule
